// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution: B-type funct3 codes and 2-bit
// saturating counter states with the saturating update function.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_state_t;

  localparam cnt_state_t CNT_RESET = CNT_WNT;

  // Saturating step toward taken/not-taken.
  function automatic cnt_state_t cnt_next(input cnt_state_t cur, input logic taken);
    cnt_state_t nxt;
    case (cur)
      CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
      default: nxt = taken ? CNT_ST  : CNT_WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Table of 2-bit saturating direction counters: one combinational read port
// and one update port. Reads see the pre-update value (no bypass).
module bht_2bit
  import branch_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  cnt_state_t cnt_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) cnt_q[i] <= CNT_RESET;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= cnt_next(cnt_q[wr_idx], wr_taken);
    end
  end

  assign rd_taken_c = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution with registered redirect and statistics.
// BRANCH_PREDICT_EN adds the 2-bit BHT; otherwise prediction is static not-taken.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             ex_pred_taken,
  input  logic             neq,
  input  logic             lt,
  input  logic             a_sign,
  input  logic             b_sign,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic        resolve_c;
  logic        slt_c;
  logic        cond_ok_c;
  logic        taken_c;
  logic        br_res_c;
  logic        mispred_c;
  logic        redir_c;
  logic [31:0] tgt_c;
  logic        pred_eff_c;
  logic        unused_c;

  // Outcome, target and redirect decision for the instruction in EX.
  always_comb begin
    resolve_c = ex_valid & ~ex_stall & ~redirect_valid;
    slt_c     = lt ^ (a_sign ^ b_sign);
    cond_ok_c = 1'b1;
    taken_c   = 1'b0;
    case (ex_funct3)
      F3_BEQ:  taken_c = ~neq;
      F3_BNE:  taken_c = neq;
      F3_BLT:  taken_c = slt_c;
      F3_BGE:  taken_c = ~slt_c;
      F3_BLTU: taken_c = lt;
      F3_BGEU: taken_c = ~lt;
      default: cond_ok_c = 1'b0;
    endcase
    br_res_c  = resolve_c & ex_is_branch & ~ex_is_jal & ~ex_is_jalr & cond_ok_c;
    mispred_c = br_res_c & (taken_c != pred_eff_c);
    redir_c   = 1'b0;
    tgt_c     = redirect_pc;
    if (resolve_c && ex_is_jal) begin
      redir_c = 1'b1;
      tgt_c   = ex_pc + ex_imm;
    end else if (resolve_c && ex_is_jalr) begin
      redir_c = 1'b1;
      tgt_c   = (ex_rs1 + ex_imm) & ~32'h1;
    end else if (mispred_c) begin
      redir_c = 1'b1;
      tgt_c   = taken_c ? (ex_pc + ex_imm) : (ex_pc + 32'd4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else begin
      redirect_valid <= redir_c;
      redirect_pc    <= tgt_c;
      if (br_res_c)  br_count      <= br_count + CNT_W'(1);
      if (mispred_c) mispred_count <= mispred_count + CNT_W'(1);
    end
  end

`ifdef BRANCH_PREDICT_EN
  bht_2bit #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (if_pc[BHT_IDX_W+1:2]),
    .rd_taken_c (if_pred_taken),
    .wr_en      (br_res_c),
    .wr_idx     (ex_pc[BHT_IDX_W+1:2]),
    .wr_taken   (taken_c)
  );
  assign pred_eff_c = ex_pred_taken;
  assign unused_c   = ^{if_pc[31:BHT_IDX_W+2], if_pc[1:0]};
`else
  // Static not-taken: IF always predicts fall-through.
  assign if_pred_taken = 1'b0;
  assign pred_eff_c    = 1'b0;
  assign unused_c      = ^{if_pc, ex_pred_taken};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit against a behavioural model
// working from real operand values; follows BRANCH_PREDICT_EN like the RTL.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        ex_pred_taken;
  logic        neq, lt, a_sign, b_sign;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] br_count, mispred_count;

  logic [31:0] cur_a, cur_b;

  logic [1:0]  m_cnt [16];
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [15:0] m_brc, m_mpc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .ex_pred_taken  (ex_pred_taken),
    .neq            (neq),
    .lt             (lt),
    .a_sign         (a_sign),
    .b_sign         (b_sign),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_PREDICT_EN
    return m_cnt[pc[5:2]] >= 2'd2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 2'd1;
    m_rv = 1'b0; m_rpc = 32'h0; m_brc = 16'h0; m_mpc = 16'h0;
  endtask

  // Apply one clock edge to the model using the currently driven EX inputs.
  task automatic model_update();
    logic tk, ok, pred, nrv;
    ok = 1'b1; tk = 1'b0; nrv = 1'b0;
    if (ex_valid && !ex_stall && !m_rv) begin
      if (ex_is_jal) begin
        nrv = 1'b1; m_rpc = ex_pc + ex_imm;
      end else if (ex_is_jalr) begin
        nrv = 1'b1; m_rpc = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
      end else if (ex_is_branch) begin
        case (ex_funct3)
          3'd0: tk = (cur_a == cur_b);
          3'd1: tk = (cur_a != cur_b);
          3'd4: tk = ($signed(cur_a) <  $signed(cur_b));
          3'd5: tk = ($signed(cur_a) >= $signed(cur_b));
          3'd6: tk = (cur_a <  cur_b);
          3'd7: tk = (cur_a >= cur_b);
          default: ok = 1'b0;
        endcase
        if (ok) begin
`ifdef BRANCH_PREDICT_EN
          pred = ex_pred_taken;
`else
          pred = 1'b0;
`endif
          m_brc = m_brc + 16'd1;
          if (tk && m_cnt[ex_pc[5:2]] != 2'd3) m_cnt[ex_pc[5:2]] = m_cnt[ex_pc[5:2]] + 2'd1;
          if (!tk && m_cnt[ex_pc[5:2]] != 2'd0) m_cnt[ex_pc[5:2]] = m_cnt[ex_pc[5:2]] - 2'd1;
          if (tk != pred) begin
            m_mpc = m_mpc + 16'd1;
            nrv   = 1'b1;
            m_rpc = tk ? ex_pc + ex_imm : ex_pc + 32'd4;
          end
        end
      end
    end
    m_rv = nrv;
  endtask

  // cls: 0 none, 1 branch, 2 jal, 3 jalr
  task automatic set_ex(input logic v, input logic st, input int cls, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input logic pred, input logic [31:0] a, input logic [31:0] b);
    ex_valid = v; ex_stall = st;
    ex_is_branch = (cls == 1); ex_is_jal = (cls == 2); ex_is_jalr = (cls == 3);
    ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_pred_taken = pred;
    cur_a = a; cur_b = b;
    neq = (a != b); lt = (a < b); a_sign = a[31]; b_sign = b[31];
  endtask

  task automatic idle();
    set_ex(1'b0, 1'b0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_pc = 32'h100; idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred got=%0b exp=0", if_pred_taken); end
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%0b exp=0", redirect_valid); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
    total++; if (br_count !== 16'h0 || mispred_count !== 16'h0)
      begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", br_count, mispred_count); end
    @(negedge clk);
  endtask

  task automatic test_blt();
    set_ex(1'b1, 1'b0, 1, 3'b100, 32'h200, 32'h10, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1);
    step();
    idle();
    total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL blt_rv got=%0b exp=1", redirect_valid); end
    total++; if (redirect_pc !== 32'h210) begin bad++; $display("FAIL blt_rpc got=%h exp=00000210", redirect_pc); end
    total++; if (mispred_count !== 16'd1) begin bad++; $display("FAIL blt_mpc got=%0d exp=1", mispred_count); end
    step();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL blt_one_cycle got=%0b exp=0", redirect_valid); end
  endtask

  task automatic test_bgeu();
    set_ex(1'b1, 1'b0, 1, 3'b111, 32'h300, 32'h40, 32'h0, 1'b1, 32'h0, 32'h1);
    step();
    idle();
    total++; if (redirect_valid !== m_rv) begin bad++; $display("FAIL bgeu_rv got=%0b exp=%0b", redirect_valid, m_rv); end
    if (m_rv) begin
      total++; if (redirect_pc !== 32'h304) begin bad++; $display("FAIL bgeu_rpc got=%h exp=00000304", redirect_pc); end
    end
    total++; if (mispred_count !== m_mpc) begin bad++; $display("FAIL bgeu_mpc got=%0d exp=%0d", mispred_count, m_mpc); end
    step();
  endtask

  task automatic test_bht_train();
    for (int k = 0; k < 3; k++) begin
      set_ex(1'b1, 1'b0, 1, 3'b000, 32'h40, 32'h20, 32'h0, 1'b0, 32'h55, 32'h55);
      step();
      idle();
      if_pc = 32'h40;
      #1;
      total++; if (if_pred_taken !== model_pred(32'h40))
        begin bad++; $display("FAIL bht_pred[%0d] got=%0b exp=%0b", k, if_pred_taken, model_pred(32'h40)); end
      total++; if (br_count !== m_brc) begin bad++; $display("FAIL bht_brc[%0d] got=%0d exp=%0d", k, br_count, m_brc); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] brc_before;
    set_ex(1'b1, 1'b0, 3, 3'd0, 32'h500, 32'h4, 32'h1001, 1'b0, 32'h0, 32'h0);
    step();
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004)
      begin bad++; $display("FAIL jalr_redirect got=%0b/%h exp=1/00001004", redirect_valid, redirect_pc); end
    brc_before = br_count;
    set_ex(1'b1, 1'b0, 1, 3'b001, 32'h600, 32'h80, 32'h0, 1'b0, 32'h1, 32'h2);
    step();
    idle();
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL squash_rv got=%0b exp=0", redirect_valid); end
    total++; if (br_count !== brc_before) begin bad++; $display("FAIL squash_brc got=%0d exp=%0d", br_count, brc_before); end
    step();
  endtask

  task automatic test_stall_reset();
    logic p0;
    if_pc = 32'h280;
    #1;
    p0 = if_pred_taken;
    for (int k = 0; k < 2; k++) begin
      set_ex(1'b1, 1'b1, 1, 3'b100, 32'h280, 32'h10, 32'h0, 1'b0, 32'h8000_0000, 32'h0);
      step();
      #1;
      total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL stall_rv[%0d] got=%0b exp=0", k, redirect_valid); end
      total++; if (if_pred_taken !== p0 || if_pred_taken !== model_pred(32'h280))
        begin bad++; $display("FAIL stall_bht[%0d] got=%0b exp=%0b", k, if_pred_taken, p0); end
    end
    ex_stall = 1'b0;
    step();
    idle();
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h290)
      begin bad++; $display("FAIL unstall_redirect got=%0b/%h exp=1/00000290", redirect_valid, redirect_pc); end
    rst_n = 1'b0;
    #1;
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL async_reset_rv got=%0b exp=0", redirect_valid); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (br_count !== 16'h0 || mispred_count !== 16'h0)
      begin bad++; $display("FAIL async_reset_counts got=%0d/%0d exp=0/0", br_count, mispred_count); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] pcs [4];
    logic [31:0] pc, a, b;
    int cls, f3sel;
    logic [2:0] f3;
    logic [2:0] f3s [7];
    pcs[0] = 32'h40; pcs[1] = 32'h84; pcs[2] = 32'h1048; pcs[3] = 32'h3C;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b100; f3s[3] = 3'b101;
    f3s[4] = 3'b110; f3s[5] = 3'b111; f3s[6] = 3'b010;
    for (int n = 0; n < 400; n++) begin
      pc = ($urandom_range(0, 4) == 4) ? ($urandom & 32'hFFFF_FFFC) : pcs[$urandom_range(0, 3)];
      cls = $urandom_range(0, 9);
      cls = (cls < 1) ? 0 : (cls < 2) ? 2 : (cls < 3) ? 3 : 1;
      f3sel = $urandom_range(0, 19);
      f3 = (f3sel > 6) ? f3s[f3sel % 6] : f3s[f3sel];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : a ^ 32'h8000_0000);
      set_ex($urandom_range(0, 7) != 0, $urandom_range(0, 4) == 0, cls, f3, pc,
             $urandom_range(0, 1) ? 32'(($urandom_range(0, 255)) << 2) : 32'hFFFF_FFF0,
             $urandom, 1'($urandom_range(0, 1)), a, b);
      if_pc = pcs[$urandom_range(0, 3)];
      #1;
      total++; if (if_pred_taken !== model_pred(if_pc))
        begin bad++; $display("FAIL rnd_pred[%0d] got=%0b exp=%0b", n, if_pred_taken, model_pred(if_pc)); end
      step();
      total++; if (redirect_valid !== m_rv)
        begin bad++; $display("FAIL rnd_rv[%0d] got=%0b exp=%0b", n, redirect_valid, m_rv); end
      if (m_rv) begin
        total++; if (redirect_pc !== m_rpc)
          begin bad++; $display("FAIL rnd_rpc[%0d] got=%h exp=%h", n, redirect_pc, m_rpc); end
      end
      total++; if (br_count !== m_brc || mispred_count !== m_mpc)
        begin bad++; $display("FAIL rnd_counts[%0d] got=%0d/%0d exp=%0d/%0d", n, br_count, mispred_count, m_brc, m_mpc); end
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_blt();
    test_bgeu();
    test_bht_train();
    test_back_to_back();
    test_stall_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

EX-stage branch resolution and direction predictor for the RV32 5-stage pipeline. Consumes the `branch_comparator` flags (`neq`, unsigned `lt`) plus operand sign bits. Derives the taken/not-taken outcome for all six B-type conditions, computes the redirect target, and detects mispredictions against the IF-stage prediction. Issues a registered redirect/flush to IF/ID, and trains a table of 2-bit saturating counters that IF looks up each cycle.

## Interface
Parameters:
- `BHT_IDX_W`, 4: log2 of counter-table entries, indexed by `pc[BHT_IDX_W+1:2]`.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_pc`  in  32  IF fetch PC for lookup.
- `if_pred_taken`  out  1  predicted direction for `if_pc`.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_stall`  in  1  EX frozen this cycle; no resolve, no update.
- `ex_is_branch` / `ex_is_jal` / `ex_is_jalr`  in  1 each  instruction class.
- `ex_funct3`  in  3  B-type condition.
- `ex_pc`, `ex_imm`, `ex_rs1`  in  32 each  PC, sign-extended immediate, forwarded rs1.
- `ex_pred_taken`  in  1  prediction carried down from IF.
- `neq`, `lt`  in  1 each  comparator flags (`lt` unsigned).
- `a_sign`, `b_sign`  in  1 each  bit 31 of comparator operands A/B.
- `redirect_valid`  out  1  registered; IF loads `redirect_pc`, IF/ID and ID/EX flush.
- `redirect_pc`  out  32  registered target.
- `br_count`, `mispred_count`  out  CNT_W  statistics.

## Operation
- Signed less-than: `slt = lt ^ (a_sign ^ b_sign)`.
- `funct3` → taken:
  - 000 → !neq
  - 001 → neq
  - 100 → slt
  - 101 → !slt
  - 110 → lt
  - 111 → !lt
  - 010/011 → not taken; never redirect.
- Resolve condition: `ex_valid & !ex_stall & !redirect_valid`.
  - `redirect_valid` high means EX holds a wrong-path instruction; it is ignored entirely: no redirect, no update, no count.
- Branch mispredict when `taken != ex_pred_taken`.
  - Target: `ex_pc+ex_imm` if taken, else `ex_pc+4`.
- JAL always redirects to `ex_pc+ex_imm`.
- JALR always redirects to `(ex_rs1+ex_imm) & ~32'h1`.
- All adds are 32-bit modulo; wrap ignored.
- BHT update, per resolved branch: counter at `ex_pc` index increments on taken and decrements on not-taken, saturating at 3/0.
- `if_pred_taken` = counter[1] at `if_pc` index (combinational read).
- Same-index read and write in one cycle: read returns the pre-update value; no bypass.
- `br_count` increments per resolved branch. `mispred_count` increments per branch mispredict; JAL/JALR are not counted. Both wrap at 2^CNT_W.

## Timing
- Redirect latency: resolve in cycle N → `redirect_valid`/`redirect_pc` high in N+1 for exactly one cycle.
- Two back-to-back redirects are impossible: the N+1 EX instruction is squashed.
- BHT write happens at the edge ending cycle N and is visible to lookup in N+1.
- Reset values:
  - `redirect_valid`=0, `redirect_pc`=0.
  - All counters = 2'b01 (weakly not-taken), so `if_pred_taken`=0.
  - `br_count`=`mispred_count`=0.
- Reset asserted mid-redirect clears `redirect_valid` immediately (asynchronous).

## Configuration
- `BRANCH_PREDICT_EN` defined: BHT present as above.
- Undefined:
  - No table; `if_pred_taken` tied 0 (static not-taken).
  - Every taken branch mispredicts and redirects; counters still operate.

## Structure
- Shared package `branch_pkg` holds:
  - `funct3` encodings (`F3_BEQ`…`F3_BGEU`);
  - 2-bit counter states and `CNT_RESET`=2'b01.
- One sub-module, `bht_2bit`:
  - parameterised table with async reset;
  - one combinational read port, one write/update port.
  - Instantiated only under `BRANCH_PREDICT_EN`.

## Test plan
- Reset, then `if_pc`=0x100 → `if_pred_taken`=0, `redirect_valid`=0, both counters 0.
- BLT, `ex_pred_taken`=0, `lt`=0, `a_sign`=1, `b_sign`=0 (A=-1, B=1): slt=1, taken → next cycle `redirect_pc`=`ex_pc`+imm=0x200+0x10=0x210, `mispred_count`=1.
- BGEU with `lt`=1, `ex_pred_taken`=1, `ex_pc`=0x300 → not taken → `redirect_pc`=0x304.
- Resolve the same BEQ at 0x40 taken three times: counter 01→10→11→11; `if_pc`=0x40 gives `if_pred_taken`=1 from the cycle after the first update.
- JALR with `ex_rs1`=0x1001, `ex_imm`=0x4 → `redirect_pc`=0x1004. The mispredicted taken branch in the following EX cycle is ignored (no second redirect, `br_count` unchanged).
- `ex_stall`=1 with a mispredicting branch → no redirect, no BHT change. Deassert `ex_stall` → redirect next cycle. Assert `rst_n`=0 during `redirect_valid` → cleared immediately.
